led_fade_driver: RTL
====================

Name: led_fade_driver

Overview:
- Downstream consumer of the 8-bit LED PIO output port of the Qsys system.
- Converts each on/off bit into a PWM-dimmed LED drive.
- Each LED ramps its brightness up or down at a programmable rate instead of switching instantly.
- Sits between the PIO `out_port` and the board LED pins; free-running, no bus interface.

Parameters:
- PRESCALE, 4096, clocks per fade tick (≥1); the fade-tick counter runs 0..PRESCALE-1.
- FADE_STEP, 8, brightness increment/decrement per fade tick (1..255).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  1 = fade/PWM mode; 0 = bypass (LEDs follow input directly)
- in_port  input  8  LED on/off request, driven by the PIO `out_port`
- led  output  8  registered LED drive, 1 = lit
- busy  output  1  registered; 1 while any LED level is between its endpoints and still ramping

Behaviour:
- Clock and reset: one clock, `clk`. `reset_n` is asynchronous and active-low.
- Reset state: in_reg=0, pwm_cnt=0, presc_cnt=0, all level[i]=0, led=0, busy=0. A reset mid-ramp abandons the ramp immediately.
- Input stage: in_reg <= in_port every clk. target[i] = in_reg[i]. The input-to-target latency is 1 clk.
- PWM counter: pwm_cnt is 8-bit, +1 every clk, wraps 255->0.
- Fade tick:
  - tick=1 for exactly one clk when presc_cnt==PRESCALE-1; presc_cnt then reloads 0, otherwise +1.
  - With PRESCALE=1, tick=1 every clk.
  - presc_cnt runs regardless of enable.
- Level update, on tick with enable=1, per LED:
  - target=1: level = min(255, level+FADE_STEP), computed 9-bit and saturated.
  - target=0: level = max(0, level-FADE_STEP), saturated at 0.
  - Level at its endpoint: holds.
- Direction reversal: if target flips mid-ramp, the next tick moves the level from its current value in the new direction. No restart from an endpoint.
- Bypass, enable=0:
  - Each clk: level[i] <= in_reg[i] ? 255 : 0, and led[i] <= in_reg[i].
  - On return to enable=1, fading resumes from these endpoint levels, so there is no glitch.
- PWM compare, enable=1: led[i] <= (level[i]==255) | (level[i] > pwm_cnt).
  - level 0 gives constant 0.
  - level 255 gives constant 1.
  - level L (1..254) gives L high cycles per 256-clk period.
- Busy flag:
  - busy <= 1 when, for any i, level[i] differs from (target[i] ? 255 : 0) and enable=1.
  - Otherwise busy <= 0.
  - Registered, so it lags the level by 1 clk.
- Simultaneous events:
  - A tick in the same clk as an in_reg change uses the old target; the new target applies from the next tick.
  - pwm_cnt wrap coinciding with a tick needs no special case.

Test Plan (PRESCALE=4, FADE_STEP=64 unless noted):
1. Reset:
   - Stimulus: assert reset_n=0 mid-ramp with in_port=FF.
   - Response: led=00, busy=0 and all levels 0 immediately, without waiting for a clk edge. After release with in_port=00, led stays 00 and busy stays 0.
2. Ramp up:
   - Stimulus: enable=1, in_port 00->01.
   - Response: level[0] at successive ticks is 64, 128, 192, 255 (saturated), and busy=1 until 1 clk after 255. Over 256 clks, led[0] duty counts high cycles of 64, 128 and 192 at those levels, then is constant 1.
3. Reversal:
   - Stimulus: in_port=01 until level[0]=128, then 00.
   - Response: subsequent ticks give 64, then 0; busy drops 1 clk after level 0; led[0] is constant 0 thereafter.
4. Bypass:
   - Stimulus: enable=0, in_port=A5.
   - Response: led=A5 two clks after the in_port change (in_reg, then led register); busy=0.
   - Stimulus: enable 0->1 with in_port=A5 unchanged.
   - Response: led stays A5 with no flicker (levels are 255/0).
5. Edge parameters:
   - Stimulus: PRESCALE=1, FADE_STEP=255, in_port 00->FF.
   - Response: all levels reach 255 on the first tick after in_reg updates, and led=FF constant one clk later.
6. Mixed LEDs:
   - Stimulus: in_port=0F then F0 mid-ramp.
   - Response: bits 3:0 ramp down while bits 7:4 ramp up, each independently saturating; busy=1 until all levels reach their endpoints.

Source files
------------

// File: rtl/led_fade_driver.sv
// led_fade_driver
// Turns the eight on/off bits of the LED PIO port into PWM-dimmed LED drives.
// Each LED ramps its brightness toward full-on or full-off at a programmable
// rate instead of switching instantly. With enable low, the LEDs follow the
// input directly and the brightness levels are pinned to their endpoints.
// A later return to fading therefore starts without a visible glitch.

module led_fade_driver #(
  parameter int PRESCALE  = 4096,  // clocks per fade tick, >= 1
  parameter int FADE_STEP = 8      // level change per fade tick, 1..255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] in_port,
  output logic [7:0] led,
  output logic       busy
);

  // Prescaler width; a PRESCALE of 1 still needs a (constant-zero) 1-bit counter.
  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [7:0]      STEP       = 8'(FADE_STEP);
  localparam logic [7:0]      LVL_MAX    = 8'hFF;
  localparam logic [7:0]      LVL_MIN    = 8'h00;

  logic [7:0]    in_reg;
  logic [7:0]    pwm_cnt;
  logic [PW-1:0] presc_cnt;
  logic          tick;
  logic [7:0]    level     [8];
  logic [7:0]    level_nxt [8];
  logic [7:0]    led_nxt;
  logic          busy_nxt;

  // Brightness increase, computed 9 bits wide and clamped at full-on.
  function automatic logic [7:0] sat_up(input logic [7:0] lvl);
    logic [8:0] sum;
    sum = {1'b0, lvl} + {1'b0, STEP};
    return sum[8] ? LVL_MAX : sum[7:0];
  endfunction

  // Brightness decrease, clamped at full-off.
  function automatic logic [7:0] sat_down(input logic [7:0] lvl);
    return (lvl < STEP) ? LVL_MIN : (lvl - STEP);
  endfunction

  // Endpoint level the LED is heading for.
  function automatic logic [7:0] endpoint(input logic on);
    return on ? LVL_MAX : LVL_MIN;
  endfunction

  // Input stage: the registered request is the per-LED target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_reg <= 8'h00;
    end else begin
      in_reg <= in_port;
    end
  end

  // Free-running PWM phase counter, wraps 255 -> 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Fade-tick prescaler, runs whether or not fading is enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_ONE;
    end
  end

  assign tick = (presc_cnt == PRESC_LAST);

  // Next level per LED: pinned in bypass, stepped toward target on each tick.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      level_nxt[i] = level[i];
      if (!enable) begin
        level_nxt[i] = endpoint(in_reg[i]);
      end else if (tick) begin
        level_nxt[i] = in_reg[i] ? sat_up(level[i]) : sat_down(level[i]);
      end
    end
  end

  // Next LED drive and ramp-in-progress flag, both from the current levels.
  always_comb begin
    led_nxt  = 8'h00;
    busy_nxt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!enable) begin
        led_nxt[i] = in_reg[i];
      end else begin
        led_nxt[i] = (level[i] == LVL_MAX) || (level[i] > pwm_cnt);
        if (level[i] != endpoint(in_reg[i])) begin
          busy_nxt = 1'b1;
        end
      end
    end
  end

  // Brightness level registers; reset abandons any ramp in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        level[i] <= LVL_MIN;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        level[i] <= level_nxt[i];
      end
    end
  end

  // Registered outputs to the board pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led  <= 8'h00;
      busy <= 1'b0;
    end else begin
      led  <= led_nxt;
      busy <= busy_nxt;
    end
  end

endmodule
